// File: rtl/sliced_alu_seq.sv
// sliced_alu_seq: digit-serial ALU. One SLICE-bit datapath is reused over
// NSL = WIDTH/SLICE cycles, LSB slice first, with a registered carry between
// slices so that add/subtract/compare results are correct across the full word.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only while idle)
//   A, B, ALUControl     operands and operation select
//   out_valid/out_ready  result handshake, result held until accepted
//   Result               registered result
//   Zero                 Result == 0
//   Carry, Overflow      carry out / signed overflow for ADD and SUB, else 0
module sliced_alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow
);

    localparam int unsigned NSL = WIDTH / SLICE;
    localparam int unsigned CW  = $clog2(NSL);
    localparam logic [CW-1:0] LastSlice = CW'(NSL - 1);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSlt  = 4'b0101;
    localparam logic [3:0] OpSltu = 4'b0110;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_flag_q;
    logic             ovf_q;
    logic             valid_q;

    // Slice datapath
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] b_eff;
    logic [SLICE-1:0] sl_res;
    logic [SLICE:0]   sum;
    logic             is_addsub;
    logic             is_arith;
    logic             inv_b;
    logic             msb_cin;
    logic             sl_ovf;
    logic             slt_bit;
    logic             sub_like_in;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < int'(NSL); i++) begin
            if (cnt_q == CW'(i)) begin
                a_sl = a_q[i*SLICE +: SLICE];
                b_sl = b_q[i*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        is_addsub = (op_q == OpAdd) || (op_q == OpSub);
        is_arith  = is_addsub || (op_q == OpSlt) || (op_q == OpSltu);
        inv_b     = is_arith && (op_q != OpAdd);
        b_eff     = inv_b ? ~b_sl : b_sl;
        sum       = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
        // Carry into the top bit of the slice, recovered from the sum bit.
        msb_cin   = a_sl[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1];
        sl_ovf    = msb_cin ^ sum[SLICE];
        slt_bit   = sum[SLICE-1] ^ sl_ovf;
        case (op_q)
            OpAdd, OpSub, OpSlt, OpSltu: sl_res = sum[SLICE-1:0];
            OpAnd:                       sl_res = a_sl & b_sl;
            OpOr:                        sl_res = a_sl | b_sl;
            OpXor:                       sl_res = a_sl ^ b_sl;
            default:                     sl_res = '0;
        endcase
    end

    // Subtract-style ops start with carry-in 1 to form the two's complement of B.
    assign sub_like_in = (ALUControl == OpSub) || (ALUControl == OpSlt) ||
                         (ALUControl == OpSltu);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            res_q        <= '0;
            carry_flag_q <= 1'b0;
            ovf_q        <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= ALUControl;
                        cnt_q   <= '0;
                        carry_q <= sub_like_in;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (is_arith) begin
                        carry_q <= sum[SLICE];
                    end
                    for (int i = 0; i < int'(NSL); i++) begin
                        if (cnt_q == CW'(i)) begin
                            res_q[i*SLICE +: SLICE] <= sl_res;
                        end
                    end
                    if (cnt_q == LastSlice) begin
                        carry_flag_q <= is_addsub & sum[SLICE];
                        ovf_q        <= is_addsub & sl_ovf;
                        // Compare ops replace the whole word on the final edge.
                        if (op_q == OpSlt) begin
                            res_q <= {{(WIDTH-1){1'b0}}, slt_bit};
                        end else if (op_q == OpSltu) begin
                            res_q <= {{(WIDTH-1){1'b0}}, ~sum[SLICE]};
                        end
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = valid_q;
    assign Result    = res_q;
    assign Zero      = (res_q == '0);
    assign Carry     = carry_flag_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_sliced_alu_seq.sv
// Self-checking bench for sliced_alu_seq: a 32/4 instance and a 16/8 instance
// share stimulus; sel16 routes the handshake to one of them at a time.
module tb_sliced_alu_seq;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        carry;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        tb_valid;
    logic        out_ready;
    logic        sel16;
    logic [31:0] tb_a;
    logic [31:0] tb_b;
    logic [3:0]  tb_op;

    logic        rdy32, vld32, zero32, cry32, ovf32;
    logic [31:0] res32;
    logic        rdy16, vld16, zero16, cry16, ovf16;
    logic [15:0] res16;

    logic        cur_in_ready, cur_out_valid, cur_zero, cur_carry, cur_ovf;
    logic [31:0] cur_result;

    int   checks;
    int   errors;
    exp_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sliced_alu_seq #(.WIDTH(32), .SLICE(4)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (tb_valid & ~sel16),
        .in_ready   (rdy32),
        .A          (tb_a),
        .B          (tb_b),
        .ALUControl (tb_op),
        .out_valid  (vld32),
        .out_ready  (out_ready),
        .Result     (res32),
        .Zero       (zero32),
        .Carry      (cry32),
        .Overflow   (ovf32)
    );

    sliced_alu_seq #(.WIDTH(16), .SLICE(8)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (tb_valid & sel16),
        .in_ready   (rdy16),
        .A          (tb_a[15:0]),
        .B          (tb_b[15:0]),
        .ALUControl (tb_op),
        .out_valid  (vld16),
        .out_ready  (out_ready),
        .Result     (res16),
        .Zero       (zero16),
        .Carry      (cry16),
        .Overflow   (ovf16)
    );

    always_comb begin
        cur_in_ready  = sel16 ? rdy16 : rdy32;
        cur_out_valid = sel16 ? vld16 : vld32;
        cur_result    = sel16 ? {16'h0000, res16} : res32;
        cur_zero      = sel16 ? zero16 : zero32;
        cur_carry     = sel16 ? cry16 : cry32;
        cur_ovf       = sel16 ? ovf16 : ovf32;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: full-word arithmetic, masked to w bits.
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] mask, a, b, bb, r;
        logic [32:0] sum;
        logic        cin, lt, ltu;
        exp_t        e;
        mask  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a     = a_in & mask;
        b     = b_in & mask;
        cin   = (op != 4'd0);
        bb    = ((op == 4'd0) ? b : ~b) & mask;
        sum   = {1'b0, a} + {1'b0, bb} + {32'b0, cin};
        ltu   = (a < b);
        lt    = (a[w-1] != b[w-1]) ? a[w-1] : ltu;
        e.carry = 1'b0;
        e.ovf   = 1'b0;
        case (op)
            4'd0, 4'd1: begin
                r       = sum[31:0] & mask;
                e.carry = sum[w];
                e.ovf   = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = {31'b0, lt};
            4'd6:    r = {31'b0, ltu};
            default: r = 32'h0;
        endcase
        e.result = r;
        e.zero   = (r == 32'h0);
        return e;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!cur_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cur_in_ready) check("idle_wait", 32'(cur_in_ready), 32'd1);
    endtask

    task automatic run_op(input bit s16, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        exp_t        e;
        int          lat;
        logic [31:0] r0;
        logic        z0, c0, v0;
        sel16 = s16;
        sb_q.push_back(model(s16 ? 16 : 32, op, a, b));
        wait_idle();
        tb_valid  = 1'b1;
        tb_a      = a;
        tb_b      = b;
        tb_op     = op;
        out_ready = !hold;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        lat = 0;
        while (!cur_out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
            check("in_ready_busy", 32'(cur_in_ready), 32'd0);
        end
        check("latency", 32'(lat), s16 ? 32'd2 : 32'd8);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("result", cur_result, e.result);
            check("zero", 32'(cur_zero), 32'(e.zero));
            check("carry", 32'(cur_carry), 32'(e.carry));
            check("overflow", 32'(cur_ovf), 32'(e.ovf));
        end
        if (hold) begin
            r0 = cur_result;
            z0 = cur_zero;
            c0 = cur_carry;
            v0 = cur_ovf;
            repeat (5) begin
                @(posedge clk);
                #1;
                check("hold_valid", 32'(cur_out_valid), 32'd1);
                check("hold_in_ready", 32'(cur_in_ready), 32'd0);
                check("hold_result", cur_result, r0);
                check("hold_flags", {29'b0, cur_zero, cur_carry, cur_ovf}, {29'b0, z0, c0, v0});
            end
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("release_valid", 32'(cur_out_valid), 32'd0);
            check("release_in_ready", 32'(cur_in_ready), 32'd1);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        tb_valid  = 1'b0;
        out_ready = 1'b1;
        sel16     = 1'b0;
        tb_a      = '0;
        tb_b      = '0;
        tb_op     = '0;
        #12;
        check("rst_in_ready", 32'(rdy32), 32'd1);
        check("rst_out_valid", 32'(vld32), 32'd0);
        check("rst_result", res32, 32'd0);
        check("rst_flags", {29'b0, zero32, cry32, ovf32}, 32'd4);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, 32/4
        run_op(1'b0, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(1'b0, 4'd1, 32'd5, 32'd7, 1'b0);
        run_op(1'b0, 4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_op(1'b0, 4'd5, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(1'b0, 4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(1'b0, 4'd4, 32'h1234_5678, 32'h1234_5678, 1'b0);
        run_op(1'b0, 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
        run_op(1'b0, 4'd3, 32'hF000_0001, 32'h0000_1230, 1'b0);
        run_op(1'b0, 4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        run_op(1'b0, 4'd5, 32'h0000_0003, 32'h8000_0000, 1'b0);
        run_op(1'b0, 4'd1, 32'h8000_0000, 32'd1, 1'b1);
        // Back-to-back issue right after the release
        run_op(1'b0, 4'd0, 32'h0000_1111, 32'h0000_2222, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, 4'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
        end

        // Reset in the middle of a RUN (counter at 3)
        sel16 = 1'b0;
        wait_idle();
        tb_valid = 1'b1;
        tb_a     = 32'hFFFF_FFFF;
        tb_b     = 32'hFFFF_FFFF;
        tb_op    = 4'd0;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(vld32), 32'd0);
        check("midrst_result", res32, 32'd0);
        check("midrst_in_ready", 32'(rdy32), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_in_ready", 32'(rdy32), 32'd1);
        check("postrst_out_valid", 32'(vld32), 32'd0);
        run_op(1'b0, 4'd0, 32'd3, 32'd4, 1'b0);

        // 16/8 instance
        run_op(1'b1, 4'd0, 32'h0000_FFFF, 32'd1, 1'b0);
        run_op(1'b1, 4'd1, 32'd5, 32'd7, 1'b0);
        run_op(1'b1, 4'd0, 32'h0000_7FFF, 32'd1, 1'b0);
        run_op(1'b1, 4'd5, 32'h0000_FFFF, 32'd1, 1'b0);
        run_op(1'b1, 4'd6, 32'h0000_FFFF, 32'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(1'b1, 4'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
